// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared types for the MEM->WB pipeline register: skid FSM states and default payload layout.
package mem_wb_pipe_reg_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_RSRC_W  = 2;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Payload layout at the default widths; the top builds its own at its parameters.
    typedef struct packed {
        logic                   reg_write;
        logic [DEF_RSRC_W-1:0]  result_src;
        logic [DEF_WIDTH-1:0]   read_data;
        logic [DEF_WIDTH-1:0]   alu_result;
        logic [DEF_RADDR_W-1:0] rd;
        logic [DEF_WIDTH-1:0]   pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB bundle: MEM-side payload with handshake, WB-side payload with handshake, flush and stall counter.
interface mem_wb_pipe_reg_if
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int RSRC_W  = DEF_RSRC_W,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic               RegWriteM;
    logic [RSRC_W-1:0]  ResultSrcM;
    logic [WIDTH-1:0]   ReadDataM;
    logic [WIDTH-1:0]   ALUResultM;
    logic [RADDR_W-1:0] RdM;
    logic [WIDTH-1:0]   PCPlus4M;
    logic               out_valid;
    logic               out_ready;
    logic               RegWriteW;
    logic [RSRC_W-1:0]  ResultSrcW;
    logic [WIDTH-1:0]   ReadDataW;
    logic [WIDTH-1:0]   ALUResultW;
    logic [RADDR_W-1:0] RdW;
    logic [WIDTH-1:0]   PCPlus4W;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output flush, in_valid, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, RdM, PCPlus4M,
        output out_ready,
        input  in_ready, out_valid, RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W,
        input  stall_cnt
    );

    modport slave (
        input  flush, in_valid, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, RdM, PCPlus4M,
        input  out_ready,
        output in_ready, out_valid, RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W,
        output stall_cnt
    );
endinterface

// File: rtl/mem_wb_pipe_reg_skid_buf.sv
// Generic 2-entry valid/ready skid register; outputs always show the main entry.
// Latency: 1 cycle accept -> out_valid when empty.
// Backpressure: in_ready drops only when both entries are held; no comb path from out_ready.
module pipe_skid_buf
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    pipe_state_t state;
    T            main_q;
    T            skid_q;
    logic        accept;
    logic        deliver;

    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Payload registers keep stale data; out_valid masks them.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (accept && deliver) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= SKID;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid buffer plus x0-safe RegWrite gating and a saturating stall counter.
// Latency: 1 cycle from accept to out_valid when empty.
// Backpressure: absorbs one extra instruction under WB stall, then deasserts in_ready.
module mem_wb_pipe_reg
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int RSRC_W  = DEF_RSRC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    mem_wb_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic               reg_write;
        logic [RSRC_W-1:0]  result_src;
        logic [WIDTH-1:0]   read_data;
        logic [WIDTH-1:0]   alu_result;
        logic [RADDR_W-1:0] rd;
        logic [WIDTH-1:0]   pc_plus4;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           in_ent;
    entry_t           out_ent;
    logic             in_rdy;
    logic             out_vld;
    logic [CNT_W-1:0] stall_q;

    assign in_ent = '{
        reg_write:  bus.RegWriteM,
        result_src: bus.ResultSrcM,
        read_data:  bus.ReadDataM,
        alu_result: bus.ALUResultM,
        rd:         bus.RdM,
        pc_plus4:   bus.PCPlus4M
    };

    pipe_skid_buf #(.T(entry_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (in_rdy),
        .in_data   (in_ent),
        .out_valid (out_vld),
        .out_ready (bus.out_ready),
        .out_data  (out_ent)
    );

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_vld;
    // Bubbles and writes to x0 must never reach the register file.
    assign bus.RegWriteW  = out_ent.reg_write & out_vld & (out_ent.rd != '0);
    assign bus.ResultSrcW = out_ent.result_src;
    assign bus.ReadDataW  = out_ent.read_data;
    assign bus.ALUResultW = out_ent.alu_result;
    assign bus.RdW        = out_ent.rd;
    assign bus.PCPlus4W   = out_ent.pc_plus4;
    assign bus.stall_cnt  = stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_vld && !bus.out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scenario bench for mem_wb_pipe_reg with a queue scoreboard tracking every accepted instruction.
module tb_mem_wb_pipe_reg;
    import mem_wb_pipe_reg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_pipe_reg_if bus ();
    mem_wb_pipe_reg_if #(.CNT_W(4)) b4 ();

    mem_wb_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus));
    mem_wb_pipe_reg #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int          total = 0;
    int          bad   = 0;
    mem_wb_t     q[$];
    logic [15:0] exp_stall = '0;

    function automatic mem_wb_t rand_ent();
        mem_wb_t e;
        e.reg_write  = 1'($urandom_range(0, 1));
        e.result_src = 2'($urandom_range(0, 3));
        e.read_data  = $urandom;
        e.alu_result = $urandom;
        e.rd         = 5'($urandom_range(0, 31));
        e.pc_plus4   = $urandom;
        return e;
    endfunction

    task automatic drive_in(input logic v, input mem_wb_t e);
        bus.in_valid   = v;
        bus.RegWriteM  = e.reg_write;
        bus.ResultSrcM = e.result_src;
        bus.ReadDataM  = e.read_data;
        bus.ALUResultM = e.alu_result;
        bus.RdM        = e.rd;
        bus.PCPlus4M   = e.pc_plus4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare head-of-queue whenever out_valid, pop on deliver, push on model-accept.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            q.delete();
            exp_stall = '0;
        end else begin
            automatic logic mdl_rdy = (q.size() < 2);
            automatic logic mdl_vld = (q.size() != 0);
            total++;
            if (bus.stall_cnt !== exp_stall) begin
                bad++;
                $display("FAIL sb_stall_cnt got=%0d want=%0d t=%0t", bus.stall_cnt, exp_stall, $time);
            end
            total++;
            if (bus.out_valid !== mdl_vld) begin
                bad++;
                $display("FAIL sb_out_valid got=%b want=%b t=%0t", bus.out_valid, mdl_vld, $time);
            end
            total++;
            if (bus.in_ready !== mdl_rdy) begin
                bad++;
                $display("FAIL sb_in_ready got=%b want=%b t=%0t", bus.in_ready, mdl_rdy, $time);
            end
            if (mdl_vld) begin
                automatic mem_wb_t e = q[0];
                automatic logic    rw = e.reg_write & (e.rd != 5'd0);
                total++;
                if (bus.ResultSrcW !== e.result_src || bus.ReadDataW !== e.read_data ||
                    bus.ALUResultW !== e.alu_result || bus.RdW !== e.rd ||
                    bus.PCPlus4W !== e.pc_plus4 || bus.RegWriteW !== rw) begin
                    bad++;
                    $display("FAIL sb_payload got alu=%h rd=%0d rw=%b pc=%h want alu=%h rd=%0d rw=%b pc=%h t=%0t",
                             bus.ALUResultW, bus.RdW, bus.RegWriteW, bus.PCPlus4W,
                             e.alu_result, e.rd, rw, e.pc_plus4, $time);
                end
            end else begin
                total++;
                if (bus.RegWriteW !== 1'b0) begin
                    bad++;
                    $display("FAIL sb_bubble_regwrite got=%b want=0 t=%0t", bus.RegWriteW, $time);
                end
            end
            if (mdl_vld && !bus.out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (mdl_vld && bus.out_ready) void'(q.pop_front());
            if (bus.flush) q.delete();
            else if (bus.in_valid && mdl_rdy) q.push_back('{bus.RegWriteM, bus.ResultSrcM, bus.ReadDataM,
                                                            bus.ALUResultM, bus.RdM, bus.PCPlus4M});
        end
    end

    task automatic apply_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.RegWriteW !== 1'b0 ||
            bus.ALUResultW !== 32'd0 || bus.PCPlus4W !== 32'd0 || bus.RdW !== 5'd0) begin
            bad++;
            $display("FAIL reset_state got vld=%b cnt=%0d rw=%b alu=%h want all zero",
                     bus.out_valid, bus.stall_cnt, bus.RegWriteW, bus.ALUResultW);
        end
        step();
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        mem_wb_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = rand_ent();
            e.alu_result = i;
            drive_in(1'b1, e);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_in_ready i=%0d got=%b want=1", i, bus.in_ready);
            end
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.ALUResultW !== 32'(i)) begin
                bad++;
                $display("FAIL stream_out i=%0d got vld=%b alu=%h want vld=1 alu=%h",
                         i, bus.out_valid, bus.ALUResultW, 32'(i));
            end
        end
        drive_in(1'b0, e);
        step();
    endtask

    task automatic test_backpressure();
        mem_wb_t a, b;
        apply_reset();
        a = rand_ent();
        b = rand_ent();
        bus.out_ready = 1'b0;
        drive_in(1'b1, a);
        step();
        drive_in(1'b1, b);
        step();
        drive_in(1'b0, a);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.ALUResultW !== a.alu_result) begin
            bad++;
            $display("FAIL bp_skid got rdy=%b vld=%b alu=%h want rdy=0 vld=1 alu=%h",
                     bus.in_ready, bus.out_valid, bus.ALUResultW, a.alu_result);
        end
        step();
        total++;
        if (bus.ALUResultW !== a.alu_result || bus.stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL bp_hold got alu=%h cnt=%0d want alu=%h cnt=2", bus.ALUResultW, bus.stall_cnt, a.alu_result);
        end
        bus.out_ready = 1'b1;
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.ALUResultW !== b.alu_result || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got vld=%b alu=%h rdy=%b want vld=1 alu=%h rdy=1",
                     bus.out_valid, bus.ALUResultW, bus.in_ready, b.alu_result);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL bp_drained got vld=%b cnt=%0d want vld=0 cnt=2", bus.out_valid, bus.stall_cnt);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive_in(1'b1, rand_ent());
        step();
        drive_in(1'b1, rand_ent());
        step();
        bus.flush = 1'b1;
        drive_in(1'b1, rand_ent());
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.RegWriteW !== 1'b0) begin
            bad++;
            $display("FAIL flush_skid got vld=%b rdy=%b rw=%b want vld=0 rdy=1 rw=0",
                     bus.out_valid, bus.in_ready, bus.RegWriteW);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_ghost i=%0d got vld=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_x0_guard();
        mem_wb_t e;
        e = rand_ent();
        e.reg_write  = 1'b1;
        e.rd         = 5'd0;
        e.alu_result = 32'hDEAD;
        bus.out_ready = 1'b0;
        drive_in(1'b1, e);
        step();
        drive_in(1'b0, e);
        total++;
        if (bus.out_valid !== 1'b1 || bus.RegWriteW !== 1'b0 || bus.ALUResultW !== 32'hDEAD) begin
            bad++;
            $display("FAIL x0_guard got vld=%b rw=%b alu=%h want vld=1 rw=0 alu=0000dead",
                     bus.out_valid, bus.RegWriteW, bus.ALUResultW);
        end
        bus.out_ready = 1'b1;
        step();
        e.rd = 5'd5;
        drive_in(1'b1, e);
        step();
        drive_in(1'b0, e);
        total++;
        if (bus.RegWriteW !== 1'b1 || bus.RdW !== 5'd5) begin
            bad++;
            $display("FAIL x5_write got rw=%b rd=%0d want rw=1 rd=5", bus.RegWriteW, bus.RdW);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive_in(1'b1, rand_ent());
        step();
        drive_in(1'b1, rand_ent());
        step();
        drive_in(1'b0, rand_ent());
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.RegWriteW !== 1'b0 ||
            bus.ResultSrcW !== 2'd0 || bus.ReadDataW !== 32'd0 || bus.ALUResultW !== 32'd0 ||
            bus.RdW !== 5'd0 || bus.PCPlus4W !== 32'd0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got vld=%b cnt=%0d alu=%h rd=%0d pc=%h rdy=%b want zeros rdy=1",
                     bus.out_valid, bus.stall_cnt, bus.ALUResultW, bus.RdW, bus.PCPlus4W, bus.in_ready);
        end
        step();
        rst = 1'b1;
        step();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after got vld=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive_in(1'($urandom_range(0, 1)), rand_ent());
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            bus.flush     = 1'($urandom_range(0, 15) == 0);
            step();
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        total++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got pending=%0d vld=%b want 0 0", q.size(), bus.out_valid);
        end
    endtask

    task automatic test_saturation();
        b4.out_ready  = 1'b0;
        b4.in_valid   = 1'b1;
        b4.RegWriteM  = 1'b1;
        b4.RdM        = 5'd7;
        b4.ALUResultM = 32'h1234;
        step();
        b4.in_valid = 1'b0;
        repeat (10) step();
        total++;
        if (b4.stall_cnt !== 4'd10 || b4.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL sat_mid got cnt=%0d vld=%b want cnt=10 vld=1", b4.stall_cnt, b4.out_valid);
        end
        repeat (10) step();
        total++;
        if (b4.stall_cnt !== 4'd15 || b4.ALUResultW !== 32'h1234) begin
            bad++;
            $display("FAIL sat_end got cnt=%0d alu=%h want cnt=15 alu=00001234", b4.stall_cnt, b4.ALUResultW);
        end
    endtask

    initial begin
        mem_wb_t z;
        z = '0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, z);
        b4.flush      = 1'b0;
        b4.in_valid   = 1'b0;
        b4.out_ready  = 1'b0;
        b4.RegWriteM  = 1'b0;
        b4.ResultSrcM = '0;
        b4.ReadDataM  = '0;
        b4.ALUResultM = '0;
        b4.RdM        = '0;
        b4.PCPlus4M   = '0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_x0_guard();
        test_reset_mid();
        test_back_to_back();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
